stream_encryptor: RTL
=====================

STREAM_ENCRYPTOR -- requirements
Module: stream_encryptor

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 6, giving the number of bytes per message frame (legal range 1..255).
REQ-002 The block SHALL have parameter SEC_LEN, default 3, giving the alphabetic shift key (legal range 0..25).
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  SHALL mean the upstream plaintext byte is valid.
REQ-006 Port in_ready  output  1  SHALL mean the block accepts a byte this cycle.
REQ-007 Port in_data  input  8  SHALL carry the ASCII plaintext byte.
REQ-008 Port out_valid  output  1  SHALL mean the ciphertext byte is valid.
REQ-009 Port out_ready  input  1  SHALL mean downstream (decryptor side) accepts the byte.
REQ-010 Port out_data  output  8  SHALL carry the ciphertext byte.
REQ-011 Port out_case  output  1  SHALL carry the case_info bit: 1 means the original byte was lowercase.
REQ-012 Port out_last  output  1  SHALL flag the final byte of a MSG_LEN frame.
REQ-013 Port frame_cnt  output  16  SHALL count completed frames (wrapping).
REQ-014 Port frame_chk  output  8  SHALL carry the frame checksum (see Configuration).

Function
REQ-015 Transfers SHALL occur only when valid and ready are both high on the same edge; the transfer rule is the same on both sides.
REQ-016 Uppercase 'A'..'Z' SHALL map to 'A'+((c-'A'+SEC_LEN) mod 26), with case bit 0.
REQ-017 Lowercase 'a'..'z' SHALL first fold to uppercase and then shift as in REQ-016, with case bit 1.
REQ-018 Non-letters SHALL pass unchanged, with case bit 0.
REQ-019 Output SHALL be registered through a 2-entry skid buffer with FSM states EMPTY, ONE and TWO.
  - EMPTY -> ONE on an input transfer.
  - ONE -> TWO on an input transfer without an output transfer.
  - ONE -> EMPTY on an output transfer without an input transfer.
  - ONE stays ONE when input and output transfer together.
  - TWO -> ONE on an output transfer.
REQ-020 in_ready SHALL be high in EMPTY and ONE, and low in TWO; it SHALL be a register output with no combinational path from out_ready.
REQ-021 Latency SHALL be 1 cycle: a byte accepted at edge N is presented on out_* after edge N when the buffer was EMPTY.
REQ-022 Byte order SHALL be preserved, with no drops or duplicates under any out_ready pattern.
REQ-023 out_data, out_case and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-024 A position counter SHALL count 0..MSG_LEN-1 on input transfers; out_last SHALL be 1 for the byte tagged MSG_LEN-1, after which the counter wraps to 0.
REQ-025 frame_cnt SHALL increment on the output transfer of a byte with out_last=1, and SHALL wrap from 0xFFFF to 0.
REQ-026 With MSG_LEN=1, every byte SHALL have out_last=1.

Reset
REQ-027 While rst is high, out_valid=0, in_ready=0, out_data=0, out_case=0, out_last=0, frame_cnt=0 and frame_chk=0 SHALL hold; the FSM SHALL be EMPTY and the position counter 0.
REQ-028 Reset asserted mid-frame SHALL discard all buffered bytes and the partial frame; in_ready SHALL rise on the first edge after rst deasserts.

Configuration
REQ-029 With STREAM_FRAME_CHK_EN defined, frame_chk SHALL hold the XOR of all ciphertext bytes of the most recently completed output frame, updated on the edge of the out_last transfer.
REQ-030 Without STREAM_FRAME_CHK_EN, frame_chk SHALL be constant 0 and no checksum logic SHALL be synthesized.

Verification
REQ-031 Input "HeLloW", SEC_LEN=3, out_ready=1 -> out_data "KHOORZ", out_case 0,1,0,1,1,0, out_last only on 'Z', frame_cnt=1.
REQ-032 Input 'z','a','!' with SEC_LEN=3 -> 'C'/1, 'D'/1, '!'/0.
REQ-033 out_ready held low for 5 cycles while in_valid is high -> exactly 2 bytes accepted, in_ready=0, out_data stable; on release, all bytes emerge in order.
REQ-034 rst pulsed after byte 3 of a frame -> outputs 0; the next 6 bytes form a complete frame with out_last on byte 6.
REQ-035 With STREAM_FRAME_CHK_EN and input "AAAAAA", SEC_LEN=0 -> frame_chk=0x00; with input "ABCDEF" -> frame_chk=0x07.
REQ-036 Random in_valid/out_ready at 50% each for 10 000 bytes -> scoreboard matches, frame_cnt equals bytes/6.

Source files
------------

// File: rtl/stream_encryptor.sv
// Shift-cipher stream encryptor with frame tagging; 1-cycle latency through a 2-entry skid buffer.
// in_ready is registered (low only when both entries are full); optional checksum via STREAM_FRAME_CHK_EN.
module stream_encryptor #(
    parameter int MSG_LEN = 6,
    parameter int SEC_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_case,
    output logic        out_last,
    output logic [15:0] frame_cnt,
    output logic [7:0]  frame_chk
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [7:0] LAST_POS = 8'(MSG_LEN - 1);
    localparam logic [7:0] SHIFT    = 8'(SEC_LEN);

    state_t     r_state, w_state_nxt;
    logic       r_in_ready;
    logic [7:0] r_pos;
    logic [7:0] r_head_data, r_skid_data;
    logic       r_head_case, r_skid_case;
    logic       r_head_last, r_skid_last;
    logic [15:0] r_frame_cnt;

    logic       w_in_xfer, w_out_xfer;
    logic       w_load_head_in, w_load_head_skid, w_load_skid;
    logic       w_is_upper, w_is_lower;
    logic [7:0] w_idx, w_sum, w_shift;
    logic [7:0] w_enc_data;
    logic       w_enc_last;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = r_in_ready;
    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign out_data   = r_head_data;
    assign out_case   = r_head_case;
    assign out_last   = r_head_last;
    assign frame_cnt  = r_frame_cnt;
    assign w_enc_last = (r_pos == LAST_POS);

    // 0x41..0x5A = 'A'..'Z', 0x61..0x7A = 'a'..'z'
    always_comb begin
        w_is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
        w_is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A);
        w_idx      = w_is_lower ? (in_data - 8'h61) : (in_data - 8'h41);
        w_sum      = w_idx + SHIFT;
        w_shift    = (w_sum >= 8'd26) ? (w_sum - 8'd26) : w_sum;
        w_enc_data = (w_is_upper || w_is_lower) ? (8'h41 + w_shift) : in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = ONE;
                    w_load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_head_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_data <= 8'h00;
            r_head_case <= 1'b0;
            r_head_last <= 1'b0;
            r_skid_data <= 8'h00;
            r_skid_case <= 1'b0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_head_in) begin
                r_head_data <= w_enc_data;
                r_head_case <= w_is_lower;
                r_head_last <= w_enc_last;
            end else if (w_load_head_skid) begin
                r_head_data <= r_skid_data;
                r_head_case <= r_skid_case;
                r_head_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_enc_data;
                r_skid_case <= w_is_lower;
                r_skid_last <= w_enc_last;
            end
        end
    end

    // Frame position is assigned at input so each byte carries its own last tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos       <= 8'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (w_in_xfer) begin
                r_pos <= w_enc_last ? 8'd0 : (r_pos + 8'd1);
            end
            if (w_out_xfer && r_head_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef STREAM_FRAME_CHK_EN
    logic [7:0] r_chk_acc;
    logic [7:0] r_frame_chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_acc   <= 8'h00;
            r_frame_chk <= 8'h00;
        end else if (w_out_xfer) begin
            if (r_head_last) begin
                r_frame_chk <= r_chk_acc ^ r_head_data;
                r_chk_acc   <= 8'h00;
            end else begin
                r_chk_acc   <= r_chk_acc ^ r_head_data;
            end
        end
    end

    assign frame_chk = r_frame_chk;
`else
    assign frame_chk = 8'h00;
`endif

endmodule
